// File: rtl/sram_stall_bridge_if.sv
// sram_stall_bridge_if: memory-side request/grant/response bus of the SRAM stall bridge.
interface sram_stall_bridge_if;
    logic        req, we, gnt, rvalid;
    logic [3:0]  wstrb;
    logic [31:0] addr, wdata, rdata;
    modport master(output req, we, addr, wstrb, wdata, input gnt, rvalid, rdata);
    modport slave(input req, we, addr, wstrb, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_stall_bridge.sv
// sram_stall_bridge: turns the one-cycle core SRAM port into a req/gnt/rvalid bus access, stalling the core meanwhile.
// Define SSB_POSTED_WRITE_EN to retire writes into a one-entry buffer without stalling the core.
module sram_stall_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_en,
    input  logic [3:0]                 cpu_wen,
    input  logic [31:0]                cpu_addr,
    input  logic [31:0]                cpu_wdata,
    output logic [31:0]                cpu_rdata,
    output logic                       cpu_stall,
    sram_stall_bridge_if.master        mem
);
`ifdef SSB_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t      state, next;
    logic [31:0] cnt;
    logic        timeout;
    assign timeout = TIMEOUT != 0 && cnt == TIMEOUT - 32'd1;
    assign mem.req = state == REQ;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next;
    // a buffered write only holds the core back if it tries another access before the grant
    always_comb begin
        next = state;
        cpu_stall = 1'b1;
        case (state)
            IDLE: begin
                cpu_stall = cpu_en && !(POSTED && |cpu_wen);
                if (cpu_en) next = REQ;
            end
            REQ: begin
                cpu_stall = (POSTED && mem.we) ? cpu_en : 1'b1;
                if (mem.gnt) next = !mem.we ? WAIT : POSTED ? IDLE : DONE;
            end
            WAIT: if (mem.rvalid || timeout) next = DONE;
            DONE: begin
                cpu_stall = 1'b0;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mem.we <= 1'b0;
            mem.addr <= '0;
            mem.wstrb <= '0;
            mem.wdata <= '0;
            cpu_rdata <= '0;
            cnt <= '0;
        end else begin
            if (state == IDLE && cpu_en) begin
                mem.we <= |cpu_wen;
                mem.addr <= cpu_addr & ~32'h3;
                mem.wstrb <= cpu_wen;
                mem.wdata <= cpu_wdata;
            end
            cnt <= state == WAIT ? cnt + 32'd1 : '0;
            if (state == WAIT && mem.rvalid) cpu_rdata <= mem.rdata;
            else if (state == WAIT && timeout) cpu_rdata <= ERR_DATA;
        end
endmodule

// File: tb/tb_sram_stall_bridge.sv
// tb_sram_stall_bridge: scoreboard bench with a programmable grant/response memory model.
module tb_sram_stall_bridge;
`ifdef SSB_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif
    logic        clk = 0, rst;
    logic        cpu_en, cpu_stall;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    int          tests = 0, fails = 0;
    int          gd = 0, rd = 1, gwait = 0, rv_cnt = 0;
    logic        rv_on = 1, stray = 0;
    logic [31:0] rd_val = 0;
    logic [68:0] bus_q[$];
    logic [31:0] rd_q[$];

    sram_stall_bridge_if bus();
    sram_stall_bridge #(.TIMEOUT(4), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .mem(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory model: grant after gd waiting cycles, read data rd cycles after the grant
    initial begin
        bus.gnt = 0;
        bus.rvalid = 0;
        bus.rdata = 0;
        forever begin
            @(posedge clk);
            #1;
            bus.gnt = 0;
            bus.rvalid = 0;
            if (bus.req) begin
                if (gwait >= gd) begin
                    bus.gnt = 1;
                    gwait = 0;
                    if (!bus.we && rv_on) rv_cnt = rd;
                end else gwait++;
            end else if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    bus.rvalid = 1;
                    bus.rdata = rd_val;
                end
            end else if (stray) begin
                bus.rvalid = 1;
                bus.rdata = 32'h5757_5757;
            end
        end
    end

    always @(negedge clk)
        if (bus.req) begin
            if (bus_q.size() == 0) chk("unexpected_req", 69'(bus_q.size()), 69'(1));
            else begin
                chk("bus_fields", {bus.we, bus.addr, bus.wstrb, bus.wdata}, bus_q[0]);
                if (bus.gnt) void'(bus_q.pop_front());
            end
        end

    task automatic access(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_stalls, input logic [31:0] exp_rd, input int chg_at);
        int stalls = 0;
        cpu_en = 1;
        cpu_wen = wen;
        cpu_addr = addr;
        cpu_wdata = wdata;
        bus_q.push_back({|wen, addr & ~32'h3, wen, wdata});
        if (wen == 0) rd_q.push_back(exp_rd);
        @(negedge clk);
        while (cpu_stall && stalls < 100) begin
            stalls++;
            if (stalls == chg_at) cpu_addr = ~addr;
            @(negedge clk);
        end
        chk("stall_cycles", 69'(stalls), 69'(exp_stalls));
        if (wen == 0) chk("cpu_rdata", 69'(cpu_rdata), 69'(rd_q.pop_front()));
        @(posedge clk);
        #1;
        cpu_en = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        cpu_en = 0;
        cpu_wen = 0;
        cpu_addr = 0;
        cpu_wdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_req", 69'(bus.req), 69'(0));
        chk("rst_we", 69'(bus.we), 69'(0));
        chk("rst_addr", 69'(bus.addr), 69'(0));
        chk("rst_stall", 69'(cpu_stall), 69'(0));
        chk("rst_rdata", 69'(cpu_rdata), 69'(0));
        @(posedge clk);
        #1;
        // read: grant immediately, data two cycles after the grant
        gd = 0; rd = 2; rv_on = 1; rd_val = 32'h1234_5678;
        access(4'h0, 32'h0000_2000, 32'h0, 4, 32'h1234_5678, 0);
        // sub-word write: word-aligned on the bus, read data untouched
        access(4'b1000, 32'h0000_1003, 32'hAB00_0000, POSTED ? 0 : 2, 32'h0, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("rdata_after_write", 69'(cpu_rdata), 69'(32'h1234_5678));
        // grant withheld: address changed by the core must not reach the bus
        gd = 10; rd = 1; rd_val = 32'hCAFE_0003;
        access(4'h0, 32'h0000_3004, 32'h0, 13, 32'hCAFE_0003, 3);
        // timeout with no response, then stray responses are ignored
        gd = 0; rv_on = 0;
        access(4'h0, 32'h0000_4000, 32'h0, 6, 32'hDEADBEEF, 0);
        stray = 1;
        repeat (3) @(posedge clk);
        #1 stray = 0;
        chk("stray_rvalid", 69'(cpu_rdata), 69'(32'hDEADBEEF));
        // reset in the middle of a read wait
        cpu_en = 1; cpu_wen = 0; cpu_addr = 32'h0000_5000; cpu_wdata = 0;
        bus_q.push_back({1'b0, 32'h0000_5000, 4'h0, 32'h0});
        repeat (3) @(negedge clk);
        chk("wait_stall", 69'(cpu_stall), 69'(1));
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("mid_rst_req", 69'(bus.req), 69'(0));
        chk("mid_rst_stall", 69'(cpu_stall), 69'(1));
        chk("mid_rst_rdata", 69'(cpu_rdata), 69'(0));
        cpu_en = 0;
        #1 chk("mid_rst_stall_idle", 69'(cpu_stall), 69'(0));
        @(posedge clk);
        #1;
        rv_on = 1;
`ifdef SSB_POSTED_WRITE_EN
        // posted write followed by a read of the same word
        gd = 2; rd = 1; rd_val = 32'h5555_AAAA;
        access(4'hF, 32'h0000_6000, 32'h5555_AAAA, 0, 32'h0, 0);
        access(4'h0, 32'h0000_6000, 32'h0, 8, 32'h5555_AAAA, 0);
`else
        gd = 1; rd = 3; rd_val = 32'h0F0F_1234;
        access(4'h3, 32'h0000_7002, 32'h0000_BEEF, 3, 32'h0, 0);
        access(4'h0, 32'h0000_7000, 32'h0, 6, 32'h0F0F_1234, 0);
`endif
        repeat (5) @(posedge clk);
        #1;
        chk("bus_q_drained", 69'(bus_q.size()), 69'(0));
        chk("rd_q_drained", 69'(rd_q.size()), 69'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
